snes_pad_responder: RTL and testbench
=====================================

Name: snes_pad_responder

Overview:
- Controller-side end of the SNES pad serial link: answers the console-side poller's latch/clock sequence by shifting out a 16-bit button frame on the serial data line.
- Used as an on-board controller emulator, so the FSM and datapath can be driven from switches or a test harness without a physical pad.
- Also serves as the bench responder for verifying the poller.
- Runs on the 50 MHz system clock and oversamples the slow poller signals.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on snes_clk and data_latch (minimum 2).
- FRAME_BITS, 16, clock pulses per frame; bits 12..FRAME_BITS-1 are padding.
- TIMEOUT_CYCLES, 4096, system clocks without a valid snes_clk rising edge in SHIFT before the frame is abandoned.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- snes_clk  input  1  poller clock, asynchronous to clk, idle high.
- data_latch  input  1  poller latch, asynchronous to clk, active high.
- buttons  input  12  pressed=1; order [0]=B,[1]=Y,[2]=Select,[3]=Start,[4]=Up,[5]=Down,[6]=Left,[7]=Right,[8]=A,[9]=X,[10]=L,[11]=R.
- serial_data  output  1  pad data line, active-low (0 = pressed).
- frame_done  output  1  one-clk pulse when the final bit has been shifted out.
- bit_index  output  5  index of the bit currently driven on serial_data, 0..FRAME_BITS.

Behaviour:
- Reset (async, reset=0): state=IDLE, serial_data=1, frame_done=0, bit_index=0, shift register all 1s, synchronisers preset to 1 (snes_clk) and 0 (data_latch), timeout counter 0.
- Inputs: snes_clk and data_latch each pass through a SYNC_STAGES synchroniser plus one edge-detect register. An edge is acted on (SYNC_STAGES+1) clks after it occurs, 3 clks at default.
- Shift register: 16 bits. Load value is {4'b1111, ~buttons}, i.e. bit k = ~buttons[k] for k<12 and 1 for padding bits. serial_data = shift_reg[0] in LATCH and SHIFT.
- State IDLE:
  - serial_data=1.
  - Synced data_latch rise -> LATCH.
- State LATCH:
  - Shift register reloads from buttons every clk, so it tracks live buttons; bit_index=0.
  - snes_clk edges are ignored.
  - Synced data_latch fall -> SHIFT, holding the last loaded value.
- State SHIFT:
  - On each synced snes_clk rising edge: shift register shifts right with 1 filled in at the MSB, bit_index increments, timeout counter clears.
  - Falling edges of snes_clk are ignored.
  - When bit_index would reach FRAME_BITS: go to DONE, pulse frame_done for 1 clk, set bit_index=FRAME_BITS.
  - If the timeout counter reaches TIMEOUT_CYCLES: go to IDLE with no frame_done.
- State DONE:
  - serial_data=0 (line held low after the frame, as on a real pad).
  - Further snes_clk edges are ignored.
  - Synced data_latch rise -> LATCH.
- Latch rise in any state, including mid-SHIFT or DONE: go to LATCH immediately and abort the current frame with no frame_done. Latch rise takes priority over a simultaneous synced clock edge.
- buttons is sampled only in LATCH. Changes during SHIFT do not affect the frame in flight.
- Reset asserted mid-frame: immediate return to reset values. The next frame requires a fresh latch.
- Widths: bit_index 5 bits, saturating at FRAME_BITS. Timeout counter width is clog2(TIMEOUT_CYCLES)+1 and saturates.

Test Plan:
- buttons=12'h001 (B), latch high 12 us then low, 16 clock pulses of 6 us -> serial_data after latch fall = 0; bits 1..11 = 1; bits 12..15 = 1; then 0 in DONE; frame_done pulses once, 3 clks after the 16th rising edge.
- buttons=12'hA5C -> reconstructing the 12 inverted bits from serial_data sampled on snes_clk falling edges yields 12'hA5C; bit_index steps 0..16.
- buttons changes from 12'h000 to 12'hFFF after the 4th pulse -> the rest of the frame still reads all 1s (unpressed); the next latch returns all 0s on bits 0..11.
- Latch pulse after 7 clock pulses -> frame aborted, no frame_done, bit_index=0, serial_data reflects the new buttons[0].
- Latch fall followed by only 3 pulses, then silence beyond 4096 clks -> state IDLE, serial_data=1, no frame_done.
- reset driven low for 1 clk mid-SHIFT (bit_index=9) -> serial_data=1 and bit_index=0 asynchronously; clock pulses without a latch leave serial_data=1.

Source files
------------

// File: rtl/snes_pad_responder.sv
// SNES controller emulator: answers the poller's latch/clock handshake by
// shifting out a 16-bit active-low button frame on serial_data.
module snes_pad_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int FRAME_BITS     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        snes_clk,
  input  logic        data_latch,
  input  logic [11:0] buttons,
  output logic        serial_data,
  output logic        frame_done,
  output logic [4:0]  bit_index
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int PAD_W = FRAME_BITS - 12;
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [4:0]       LAST_IDX = 5'(FRAME_BITS - 1);
  localparam logic [4:0]       FULL_IDX = 5'(FRAME_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_SHIFT,
    S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_p0;
  logic [SYNC_STAGES-1:0] latch_sync_p0;
  logic                   clk_d_p1;
  logic                   latch_d_p1;
  logic                   clk_rise;
  logic                   latch_rise;
  logic                   latch_fall;

  state_t                 state;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [FRAME_BITS-1:0]  load_val;
  logic [FRAME_BITS-1:0]  shift_nxt;
  logic [TMO_W-1:0]       tmo_cnt;

  // Stage p0: synchronisers; stage p1: edge-detect registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_p0   <= '1;
      latch_sync_p0 <= '0;
      clk_d_p1      <= 1'b1;
      latch_d_p1    <= 1'b0;
    end else begin
      clk_sync_p0   <= {clk_sync_p0[SYNC_STAGES-2:0], snes_clk};
      latch_sync_p0 <= {latch_sync_p0[SYNC_STAGES-2:0], data_latch};
      clk_d_p1      <= clk_sync_p0[SYNC_STAGES-1];
      latch_d_p1    <= latch_sync_p0[SYNC_STAGES-1];
    end
  end

  assign clk_rise   =  clk_sync_p0[SYNC_STAGES-1]   & ~clk_d_p1;
  assign latch_rise =  latch_sync_p0[SYNC_STAGES-1] & ~latch_d_p1;
  assign latch_fall = ~latch_sync_p0[SYNC_STAGES-1] &  latch_d_p1;

  assign load_val  = {{PAD_W{1'b1}}, ~buttons};
  assign shift_nxt = {1'b1, shift_reg[FRAME_BITS-1:1]};

  // Stage p2: frame FSM with registered line outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      shift_reg   <= '1;
      serial_data <= 1'b1;
      frame_done  <= 1'b0;
      bit_index   <= '0;
      tmo_cnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (latch_rise) begin
        // A new latch always wins, aborting whatever frame was in flight
        state       <= S_LATCH;
        shift_reg   <= load_val;
        serial_data <= load_val[0];
        bit_index   <= '0;
        tmo_cnt     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            serial_data <= 1'b1;
          end
          S_LATCH: begin
            bit_index <= '0;
            tmo_cnt   <= '0;
            if (latch_fall) begin
              state       <= S_SHIFT;
              serial_data <= shift_reg[0];
            end else begin
              shift_reg   <= load_val;
              serial_data <= load_val[0];
            end
          end
          S_SHIFT: begin
            if (clk_rise) begin
              tmo_cnt   <= '0;
              shift_reg <= shift_nxt;
              if (bit_index >= LAST_IDX) begin
                state       <= S_DONE;
                frame_done  <= 1'b1;
                bit_index   <= FULL_IDX;
                serial_data <= 1'b0;
              end else begin
                bit_index   <= bit_index + 5'd1;
                serial_data <= shift_nxt[0];
              end
            end else if (tmo_cnt >= TMO_MAX) begin
              state       <= S_IDLE;
              shift_reg   <= '1;
              serial_data <= 1'b1;
              bit_index   <= '0;
              tmo_cnt     <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          S_DONE: begin
            serial_data <= 1'b0;
          end
          default: begin
            state       <= S_IDLE;
            serial_data <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snes_pad_responder.sv
// Bench for snes_pad_responder: directed poller scenarios plus randomized
// frames checked against a bit-level model of the pad frame.
module tb_snes_pad_responder;

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic        snes_clk   = 1'b1;
  logic        data_latch = 1'b0;
  logic [11:0] buttons    = '0;
  logic        serial_data;
  logic        frame_done;
  logic [4:0]  bit_index;

  int n_chk  = 0;
  int n_fail = 0;
  int fd_cnt = 0;

  snes_pad_responder dut (
    .clk        (clk),
    .reset      (reset),
    .snes_clk   (snes_clk),
    .data_latch (data_latch),
    .buttons    (buttons),
    .serial_data(serial_data),
    .frame_done (frame_done),
    .bit_index  (bit_index)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A pad drives 0 for each pressed button, and 1 for every padding bit.
  function automatic logic [15:0] model_frame(input logic [11:0] b);
    logic [15:0] f;
    for (int k = 0; k < 16; k++) f[k] = (k < 12) ? !b[k] : 1'b1;
    return f;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latch_frame(input logic [11:0] b, input int hi);
    buttons    = b;
    data_latch = 1'b1;
    wait_clks(hi);
    data_latch = 1'b0;
    wait_clks(6);
  endtask

  task automatic pulse_bits(input logic [15:0] exp, input int first, input int n,
                            input int half, input string tag, output logic [15:0] seen);
    seen = '0;
    for (int k = first; k < first + n; k++) begin
      seen[k] = serial_data;
      chk($sformatf("%s bit%0d", tag, k), {31'd0, serial_data}, {31'd0, exp[k]});
      chk($sformatf("%s idx%0d", tag, k), {27'd0, bit_index}, k);
      snes_clk = 1'b0;
      wait_clks(half);
      snes_clk = 1'b1;
      wait_clks(half);
    end
  endtask

  task automatic pulses_nochk(input int n, input int half);
    for (int k = 0; k < n; k++) begin
      snes_clk = 1'b0;
      wait_clks(half);
      snes_clk = 1'b1;
      wait_clks(half);
    end
  endtask

  initial begin
    logic [15:0] seen;
    logic [11:0] b;
    int f0, half, hi;

    // Reset state
    wait_clks(3);
    chk("rst serial", {31'd0, serial_data}, 1);
    chk("rst done", {31'd0, frame_done}, 0);
    chk("rst idx", {27'd0, bit_index}, 0);
    reset = 1'b1;
    wait_clks(5);
    chk("idle serial", {31'd0, serial_data}, 1);

    // B pressed, full-speed frame, frame_done timing
    f0 = fd_cnt;
    latch_frame(12'h001, 600);
    pulse_bits(model_frame(12'h001), 0, 15, 150, "b_only", seen);
    chk("b_only bit15", {31'd0, serial_data}, 1);
    chk("b_only idx15", {27'd0, bit_index}, 15);
    snes_clk = 1'b0;
    wait_clks(150);
    snes_clk = 1'b1;
    wait_clks(2);
    chk("done early", {31'd0, frame_done}, 0);
    wait_clks(1);
    chk("done pulse", {31'd0, frame_done}, 1);
    wait_clks(1);
    chk("done after", {31'd0, frame_done}, 0);
    chk("done serial", {31'd0, serial_data}, 0);
    chk("done idx", {27'd0, bit_index}, 16);
    pulses_nochk(1, 150);
    chk("done hold serial", {31'd0, serial_data}, 0);
    chk("done hold idx", {27'd0, bit_index}, 16);
    chk("done count", fd_cnt - f0, 1);

    // Reconstruct 12'hA5C from the line
    latch_frame(12'hA5C, 600);
    pulse_bits(model_frame(12'hA5C), 0, 16, 150, "a5c", seen);
    chk("a5c recon", {20'd0, ~seen[11:0]}, 32'hA5C);
    chk("a5c idx", {27'd0, bit_index}, 16);

    // Buttons changing mid-frame do not disturb the frame in flight
    f0 = fd_cnt;
    latch_frame(12'h000, 600);
    pulse_bits(model_frame(12'h000), 0, 4, 150, "hold", seen);
    buttons = 12'hFFF;
    pulse_bits(model_frame(12'h000), 4, 12, 150, "hold", seen);
    latch_frame(12'hFFF, 600);
    pulse_bits(model_frame(12'hFFF), 0, 16, 150, "all", seen);
    chk("hold count", fd_cnt - f0, 2);

    // Latch mid-frame aborts; LATCH follows live buttons
    latch_frame(12'h000, 600);
    pulse_bits(model_frame(12'h000), 0, 7, 150, "abort", seen);
    f0 = fd_cnt;
    buttons    = 12'h001;
    data_latch = 1'b1;
    wait_clks(6);
    chk("abort serial", {31'd0, serial_data}, 0);
    chk("abort idx", {27'd0, bit_index}, 0);
    buttons = 12'h002;
    wait_clks(3);
    chk("latch live", {31'd0, serial_data}, 1);
    buttons = 12'h001;
    wait_clks(3);
    data_latch = 1'b0;
    wait_clks(6);
    chk("abort count", fd_cnt - f0, 0);
    pulse_bits(model_frame(12'h001), 0, 16, 150, "reframe", seen);
    chk("reframe count", fd_cnt - f0, 1);

    // Poller goes silent: frame abandoned after the timeout
    f0 = fd_cnt;
    latch_frame(12'h008, 600);
    pulse_bits(model_frame(12'h008), 0, 3, 150, "tmo", seen);
    wait_clks(3700);
    chk("tmo pre serial", {31'd0, serial_data}, 0);
    chk("tmo pre idx", {27'd0, bit_index}, 3);
    wait_clks(400);
    chk("tmo serial", {31'd0, serial_data}, 1);
    pulses_nochk(3, 150);
    chk("tmo idle serial", {31'd0, serial_data}, 1);
    chk("tmo count", fd_cnt - f0, 0);

    // Asynchronous reset mid-frame
    f0 = fd_cnt;
    latch_frame(12'h200, 600);
    pulse_bits(model_frame(12'h200), 0, 9, 150, "rstmid", seen);
    chk("rstmid idx9", {27'd0, bit_index}, 9);
    chk("rstmid bit9", {31'd0, serial_data}, 0);
    reset = 1'b0;
    #2;
    chk("async serial", {31'd0, serial_data}, 1);
    chk("async idx", {27'd0, bit_index}, 0);
    wait_clks(1);
    reset = 1'b1;
    pulses_nochk(5, 150);
    chk("post rst serial", {31'd0, serial_data}, 1);
    chk("post rst idx", {27'd0, bit_index}, 0);
    chk("post rst count", fd_cnt - f0, 0);

    // Randomized frames at varied poll rates
    for (int r = 0; r < 12; r++) begin
      b    = 12'($urandom);
      half = $urandom_range(4, 12);
      hi   = $urandom_range(4, 30);
      f0   = fd_cnt;
      latch_frame(b, hi);
      pulse_bits(model_frame(b), 0, 16, half, $sformatf("rand%0d", r), seen);
      wait_clks(2);
      chk($sformatf("rand%0d done serial", r), {31'd0, serial_data}, 0);
      chk($sformatf("rand%0d done idx", r), {27'd0, bit_index}, 16);
      chk($sformatf("rand%0d count", r), fd_cnt - f0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
